led_frame_buffer: RTL and testbench

- Double-buffered pixel store that feeds the LED matrix scan driver.
- Holds two 64x64 frames of 8-bit pixels ({X,X,R,R,G,G,B,B}).
- The scan driver reads the front frame through two independent ports: top half (rows 0-31) and bottom half (rows 32-63).
- The CPU/bus side writes the back frame, requests a swap (honoured on the driver's end-of-frame `done` pulse), and can bulk-clear the back frame.

---
 rtl/led_pkg.sv | 35 +++
 rtl/pixel_ram.sv | 35 +++
 rtl/led_frame_buffer.sv | 138 +++++++++++++
 tb/tb_led_frame_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the LED matrix frame buffer.
// Pixel layout is {X,X,R,R,G,G,B,B}.
package led_pkg;

    localparam int PIXEL_WIDTH     = 8;
    localparam int HALF_ADDR_WIDTH = 11;
    localparam int COLUMNS         = 64;
    localparam int ROWS_PER_HALF   = 32;

    localparam int RED   = 2;
    localparam int GREEN = 1;
    localparam int BLUE  = 0;

    localparam int RED_OFFSET   = 4;
    localparam int GREEN_OFFSET = 2;
    localparam int BLUE_OFFSET  = 0;

    typedef enum logic {
        IDLE,
        CLEARING
    } FrameBufferState;

    function automatic logic [1:0] colour_field(
        input logic [PIXEL_WIDTH-1:0] px,
        input int                     ch
    );
        logic [1:0] f;
        f = '0;
        if (ch == RED)   f = px[RED_OFFSET+:2];
        if (ch == GREEN) f = px[GREEN_OFFSET+:2];
        if (ch == BLUE)  f = px[BLUE_OFFSET+:2];
        return f;
    endfunction

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Only the read register is reset; the array contents are not.
module pixel_ram #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered 64x64 pixel store for the LED scan driver, with
// frame-synchronous swap and a bulk clear of the back frame.
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pixelAddress0,
    output logic [PIXEL_WIDTH-1:0] pixel0,
    input  logic [ADDR_WIDTH-1:0]  pixelAddress1,
    output logic [PIXEL_WIDTH-1:0] pixel1,
    input  logic                   done,
    input  logic                   writeEnable,
    input  logic [ADDR_WIDTH:0]    writeAddress,
    input  logic [PIXEL_WIDTH-1:0] writeData,
    input  logic                   swapRequest,
    output logic                   swapPending,
    output logic                   swapAck,
    input  logic                   clearRequest,
    input  logic [PIXEL_WIDTH-1:0] clearValue,
    output logic                   busy,
    output logic                   clearDone,
    output logic                   frontBuffer
);

    FrameBufferState state_q, state_d;

    logic                   front_q, front_d;
    logic                   pend_q, pend_d;
    logic                   ack_q, ack_d;
    logic                   cdone_q, cdone_d;
    logic                   sel_q;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PIXEL_WIDTH-1:0] fill_q, fill_d;

    logic                   clearing;
    logic                   cpu_we;
    logic                   do_swap;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [PIXEL_WIDTH-1:0] wdata;
    logic [3:0]             ram_we;
    logic [PIXEL_WIDTH-1:0] rdata [4];

    assign clearing = (state_q == CLEARING);
    assign cpu_we   = writeEnable && !clearing;
    assign do_swap  = done && (pend_q || swapRequest) && !clearing;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        cdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clearRequest) begin
                    fill_d  = clearValue;
                    cnt_d   = '0;
                    state_d = CLEARING;
                end
            end
            CLEARING: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    cdone_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        front_d = front_q ^ do_swap;
        pend_d  = do_swap ? 1'b0 : (pend_q || swapRequest);
        ack_d   = do_swap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            cdone_q <= 1'b0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            cdone_q <= cdone_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            sel_q   <= front_q;
        end
    end

    // Clear drives both halves of the back frame; CPU writes pick one half.
    assign waddr = clearing ? cnt_q : writeAddress[ADDR_WIDTH-1:0];
    assign wdata = clearing ? fill_q : writeData;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        localparam logic F = 1'(b >> 1);
        localparam logic H = 1'(b & 1);

        assign ram_we[b] = (front_q != F) &&
                           (clearing ||
                            (cpu_we && (writeAddress[ADDR_WIDTH] == H)));

        pixel_ram #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(PIXEL_WIDTH)
        ) u_ram (
            .clk    (clk),
            .rst    (rst),
            .we_i   (ram_we[b]),
            .waddr_i(waddr),
            .wdata_i(wdata),
            .raddr_i(H ? pixelAddress1 : pixelAddress0),
            .rdata_o(rdata[b])
        );
    end

    // sel_q is the front index that was live when the read address was sampled.
    assign pixel0      = sel_q ? rdata[2] : rdata[0];
    assign pixel1      = sel_q ? rdata[3] : rdata[1];
    assign swapPending = pend_q;
    assign swapAck     = ack_q;
    assign busy        = clearing;
    assign clearDone   = cdone_q;
    assign frontBuffer = front_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed self-checking bench for led_frame_buffer.
// Covers reset, write/swap visibility, swap corner cases, clear and reset mid-clear.
module tb_led_frame_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] pixelAddress0 = '0;
    logic [7:0]  pixel0;
    logic [10:0] pixelAddress1 = '0;
    logic [7:0]  pixel1;
    logic        done = 1'b0;
    logic        writeEnable = 1'b0;
    logic [11:0] writeAddress = '0;
    logic [7:0]  writeData = '0;
    logic        swapRequest = 1'b0;
    logic        swapPending;
    logic        swapAck;
    logic        clearRequest = 1'b0;
    logic [7:0]  clearValue = '0;
    logic        busy;
    logic        clearDone;
    logic        frontBuffer;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int pulses;

    always #5 clk = ~clk;

    led_frame_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .pixelAddress0(pixelAddress0),
        .pixel0       (pixel0),
        .pixelAddress1(pixelAddress1),
        .pixel1       (pixel1),
        .done         (done),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .swapRequest  (swapRequest),
        .swapPending  (swapPending),
        .swapAck      (swapAck),
        .clearRequest (clearRequest),
        .clearValue   (clearValue),
        .busy         (busy),
        .clearDone    (clearDone),
        .frontBuffer  (frontBuffer)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        writeEnable  = 1'b1;
        writeAddress = a;
        writeData    = d;
        tick();
        writeEnable  = 1'b0;
    endtask

    task automatic clear_run(input logic [7:0] v, input bit inject,
                             input int limit, output int c, output int p);
        clearRequest = 1'b1;
        clearValue   = v;
        tick();
        clearRequest = 1'b0;
        c = 0;
        p = 0;
        while (busy && c < limit) begin
            c++;
            writeEnable  = inject && (c == 100);
            writeAddress = 12'h007;
            writeData    = 8'h55;
            swapRequest  = inject && (c == 200);
            done         = inject && (c == 300);
            tick();
            if (clearDone) p++;
        end
        writeEnable = 1'b0;
        swapRequest = 1'b0;
        done        = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pixel0", pixel0, 0);
        chk("rst_pixel1", pixel1, 0);
        chk("rst_front", frontBuffer, 0);
        chk("rst_pend", swapPending, 0);
        chk("rst_ack", swapAck, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cdone", clearDone, 0);
        #3 rst = 1'b1;
        tick();

        // Initialise frame 1, swap, initialise frame 0.
        clear_run(8'h00, 1'b0, 3000, cyc, pulses);
        chk("clr0_cycles", cyc, 2048);
        chk("clr0_pulses", pulses, 1);
        swapRequest = 1'b1;
        done        = 1'b1;
        tick();
        swapRequest = 1'b0;
        done        = 1'b0;
        chk("same_cyc_front", frontBuffer, 1);
        chk("same_cyc_ack", swapAck, 1);
        chk("same_cyc_pend", swapPending, 0);
        tick();
        chk("ack_one_cycle", swapAck, 0);
        clear_run(8'h00, 1'b0, 3000, cyc, pulses);
        chk("clr1_cycles", cyc, 2048);

        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_nopend_front", frontBuffer, 1);
        chk("done_nopend_ack", swapAck, 0);

        // Back frame is 0 now.
        wr(12'h005, 8'h15);
        wr(12'h805, 8'h2A);
        pixelAddress0 = 11'd5;
        pixelAddress1 = 11'd5;
        tick();
        chk("prewsap_pixel0", pixel0, 8'h00);
        chk("preswap_pixel1", pixel1, 8'h00);
        swapRequest = 1'b1;
        tick();
        swapRequest = 1'b0;
        chk("req_pend", swapPending, 1);
        chk("req_front", frontBuffer, 1);
        tick();
        chk("pend_hold", swapPending, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("swap_ack", swapAck, 1);
        chk("swap_front", frontBuffer, 0);
        chk("swap_pend", swapPending, 0);
        pixelAddress0 = 11'd6;
        tick();
        chk("lat_pixel0_a6", pixel0, 8'h00);
        chk("post_pixel1", pixel1, 8'h2A);
        pixelAddress0 = 11'd5;
        tick();
        chk("lat_pixel0_a5", pixel0, 8'h15);

        // Clear frame 1 with a dropped write and deferred swap inside.
        clear_run(8'h3F, 1'b1, 3000, cyc, pulses);
        chk("clr3f_cycles", cyc, 2048);
        chk("clr3f_pulses", pulses, 1);
        chk("clr3f_cdone", clearDone, 1);
        chk("clr3f_pend", swapPending, 1);
        chk("clr3f_front", frontBuffer, 0);
        tick();
        chk("cdone_one_cycle", clearDone, 0);
        chk("pend_after_clr", swapPending, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("defer_swap_front", frontBuffer, 1);
        chk("defer_swap_ack", swapAck, 1);
        for (int a = 0; a < 2048; a++) begin
            pixelAddress0 = 11'(a);
            pixelAddress1 = 11'(a);
            tick();
            chk("sweep_top", pixel0, 8'h3F);
            chk("sweep_bot", pixel1, 8'h3F);
        end

        // Reset mid-clear.
        swapRequest = 1'b1;
        tick();
        swapRequest = 1'b0;
        clear_run(8'h11, 1'b0, 1000, cyc, pulses);
        chk("mid_busy", busy, 1);
        chk("mid_pend", swapPending, 1);
        rst = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_pend", swapPending, 0);
        chk("async_front", frontBuffer, 0);
        chk("async_pixel0", pixel0, 0);
        #2 rst = 1'b1;
        tick();
        clear_run(8'h22, 1'b0, 3000, cyc, pulses);
        chk("clr22_cycles", cyc, 2048);
        chk("clr22_pulses", pulses, 1);
        swapRequest = 1'b1;
        done        = 1'b1;
        tick();
        swapRequest = 1'b0;
        done        = 1'b0;
        chk("clr22_front", frontBuffer, 1);
        for (int i = 0; i < 3; i++) begin
            pixelAddress0 = (i == 0) ? 11'd0 : (i == 1) ? 11'd1000 : 11'd2047;
            pixelAddress1 = pixelAddress0;
            tick();
            chk("clr22_top", pixel0, 8'h22);
            chk("clr22_bot", pixel1, 8'h22);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
